// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, flag bit positions and FSM state type for alu_pipe
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SHL = 4'd5,
        ALU_SHR = 4'd6,
        ALU_SLT = 4'd7,
        ALU_MUL = 4'd8
    } alu_op_e;

    localparam int FLG_ZERO  = 0;
    localparam int FLG_CARRY = 1;
    localparam int FLG_OVF   = 2;
    localparam int FLG_NEG   = 3;
    localparam int FLG_ERR   = 4;
    localparam int FLG_W     = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MULT = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - iterative shift-add unsigned multiplier, one step per cycle
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 ack,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]   sum;

    // Upper half accumulates the multiplicand; lower half shifts the multiplier out.
    always_comb begin
        sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b0;
            cnt   <= '0;
            mcand <= '0;
            prod  <= '0;
        end else if (start && !busy) begin
            busy  <= 1'b1;
            cnt   <= '0;
            mcand <= a;
            prod  <= {{WIDTH{1'b0}}, b};
        end else if (busy) begin
            if (cnt != LAST) begin
                prod <= {sum, prod[WIDTH-1:1]};
                cnt  <= cnt + 1'b1;
            end else if (ack) begin
                busy <= 1'b0;
            end
        end
    end

    assign done    = busy && (cnt == LAST);
    assign product = prod;

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered WIDTH-bit ALU with valid/ready handshakes and iterative multiply
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [3:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       flags
);

    localparam int SHW = $clog2(WIDTH);

    // Returns {flags, result} for every opcode except MUL.
    function automatic logic [FLG_W+WIDTH-1:0] alu_eval(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        logic [FLG_W-1:0] f;
        logic [WIDTH:0]   ext;
        r   = '0;
        f   = '0;
        ext = '0;
        case (op)
            ALU_ADD: begin
                ext        = {1'b0, a} + {1'b0, b};
                r          = ext[WIDTH-1:0];
                f[FLG_CARRY] = ext[WIDTH];
                f[FLG_OVF] = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                ext        = {1'b0, a} - {1'b0, b};
                r          = ext[WIDTH-1:0];
                f[FLG_CARRY] = ext[WIDTH];
                f[FLG_OVF] = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_XOR: r = a ^ b;
            ALU_SHL: r = a << b[SHW-1:0];
            ALU_SHR: r = a >> b[SHW-1:0];
            ALU_SLT: r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: f[FLG_ERR] = 1'b1;
        endcase
        f[FLG_ZERO] = (r == '0);
        f[FLG_NEG]  = r[WIDTH-1];
        return {f, r};
    endfunction

    alu_state_e state_q, state_d;

    logic                 out_free;
    logic                 accept;
    logic                 is_mul;
    logic                 mul_start;
    logic                 mul_busy;
    logic                 mul_done;
    logic                 load_single;
    logic                 load_mul;
    logic [2*WIDTH-1:0]   mul_prod;
    logic [WIDTH-1:0]     load_result;
    logic [FLG_W-1:0]     load_flags;

    assign out_free    = !out_valid || out_ready;
    assign in_ready    = !rst && (state_q == ST_IDLE) && out_free;
    assign accept      = in_valid && in_ready;
    assign is_mul      = (alu_op == ALU_MUL);
    assign mul_start   = accept && is_mul && !mul_busy;
    assign load_single = accept && !is_mul;
    // A finished multiply waits in the sequencer until the output register is free.
    assign load_mul    = (state_q == ST_MULT) && mul_done && out_free;

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (op_a),
        .b       (op_b),
        .ack     (load_mul),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_comb begin
        load_result = '0;
        load_flags  = '0;
        if (load_mul) begin
            load_result            = mul_prod[WIDTH-1:0];
            load_flags[FLG_ZERO]   = (mul_prod[WIDTH-1:0] == '0);
            load_flags[FLG_NEG]    = mul_prod[WIDTH-1];
            load_flags[FLG_CARRY]  = |mul_prod[2*WIDTH-1:WIDTH];
            load_flags[FLG_OVF]    = |mul_prod[2*WIDTH-1:WIDTH];
        end else begin
            {load_flags, load_result} = alu_eval(alu_op, op_a, op_b);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (mul_start) state_d = ST_MULT;
            ST_MULT: if (load_mul)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else if (load_single || load_mul) begin
            out_valid <= 1'b1;
            result    <= load_result;
            flags     <= load_flags;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed self-checking bench for alu_pipe at WIDTH=8
module tb_alu_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [3:0] alu_op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic [4:0] flags;

    int n_checks = 0;
    int n_pass   = 0;

    alu_pipe #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .alu_op    (alu_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1;
        alu_op   = op;
        op_a     = a;
        op_b     = b;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op_a = 8'h00; op_b = 8'h00; alu_op = 4'h0;
        repeat (3) step();
        n_checks++;
        if ({out_valid, result, flags} !== 14'b0)
            $display("FAIL reset_outputs: got v=%b r=%h f=%b, want 0/00/00000", out_valid, result, flags);
        else n_pass++;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b, want 0", in_ready);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_release_in_ready: got %b, want 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_add_wrap();
        drive(4'd0, 8'hFF, 8'h01);
        step();
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, result, flags} !== {1'b1, 8'h00, 5'b00011})
            $display("FAIL add_wrap: got v=%b r=%h f=%b, want 1/00/00011", out_valid, result, flags);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        drive(4'd1, 8'h80, 8'h01);
        step();
        n_checks++;
        if ({out_valid, result, flags} !== {1'b1, 8'h7F, 5'b00100})
            $display("FAIL sub_ovf: got v=%b r=%h f=%b, want 1/7f/00100", out_valid, result, flags);
        else n_pass++;
        drive(4'd7, 8'h80, 8'h01);
        step();
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, result, flags} !== {1'b1, 8'h01, 5'b00000})
            $display("FAIL slt_signed: got v=%b r=%h f=%b, want 1/01/00000", out_valid, result, flags);
        else n_pass++;
        step();
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL drain_after_consume: got out_valid=%b, want 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_ops_table();
        logic [3:0] ops [6] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        logic [7:0] as  [6] = '{8'h7F, 8'hF0, 8'h0C, 8'hFF, 8'h81, 8'h81};
        logic [7:0] bs  [6] = '{8'h01, 8'h3C, 8'h30, 8'h0F, 8'h09, 8'h0F};
        logic [7:0] rs  [6] = '{8'h80, 8'h30, 8'h3C, 8'hF0, 8'h02, 8'h01};
        logic [4:0] fs  [6] = '{5'b01100, 5'b00000, 5'b00000, 5'b01000, 5'b00000, 5'b00000};
        for (int i = 0; i < 6; i++) begin
            drive(ops[i], as[i], bs[i]);
            step();
            n_checks++;
            if ({out_valid, result, flags} !== {1'b1, rs[i], fs[i]})
                $display("FAIL op_table[%0d] op=%0d: got v=%b r=%h f=%b, want 1/%h/%b",
                         i, ops[i], out_valid, result, flags, rs[i], fs[i]);
            else n_pass++;
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_mul();
        drive(4'd8, 8'h10, 8'h11);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if ({out_valid, in_ready} !== 2'b00)
                $display("FAIL mul_busy[%0d]: got out_valid=%b in_ready=%b, want 0/0", i, out_valid, in_ready);
            else n_pass++;
            step();
        end
        n_checks++;
        if ({out_valid, result, flags} !== {1'b1, 8'h10, 5'b00110})
            $display("FAIL mul_result: got v=%b r=%h f=%b, want 1/10/00110", out_valid, result, flags);
        else n_pass++;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL mul_done_in_ready: got %b, want 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_hold();
        out_ready = 1'b0;
        drive(4'd0, 8'h03, 8'h04);
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if ({out_valid, in_ready, result, flags} !== {1'b1, 1'b0, 8'h10, 5'b00110})
                $display("FAIL hold[%0d]: got v=%b rdy=%b r=%h f=%b, want 1/0/10/00110",
                         i, out_valid, in_ready, result, flags);
            else n_pass++;
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL hold_release_in_ready: got %b, want 1", in_ready);
        else n_pass++;
        step();
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, result, flags} !== {1'b1, 8'h07, 5'b00000})
            $display("FAIL hold_handoff: got v=%b r=%h f=%b, want 1/07/00000", out_valid, result, flags);
        else n_pass++;
        step();
    endtask

    task automatic test_reset_mid_mul();
        drive(4'd8, 8'h05, 8'h07);
        step();
        in_valid = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        n_checks++;
        if ({out_valid, in_ready} !== 2'b00)
            $display("FAIL abort_reset: got out_valid=%b in_ready=%b, want 0/0", out_valid, in_ready);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL abort_in_ready: got %b, want 1", in_ready);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++;
            if ({out_valid, in_ready} !== 2'b01)
                $display("FAIL abort_quiet[%0d]: got out_valid=%b in_ready=%b, want 0/1", i, out_valid, in_ready);
            else n_pass++;
        end
        drive(4'd2, 8'hF0, 8'h3C);
        step();
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, result, flags} !== {1'b1, 8'h30, 5'b00000})
            $display("FAIL and_after_abort: got v=%b r=%h f=%b, want 1/30/00000", out_valid, result, flags);
        else n_pass++;
        step();
    endtask

    task automatic test_undefined();
        drive(4'hC, 8'h5A, 8'h33);
        step();
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, result, flags} !== {1'b1, 8'h00, 5'b10001})
            $display("FAIL undef_op: got v=%b r=%h f=%b, want 1/00/10001", out_valid, result, flags);
        else n_pass++;
        step();
    endtask

    initial begin
        test_reset();
        test_add_wrap();
        test_back_to_back();
        test_ops_table();
        test_mul();
        test_hold();
        test_reset_mid_mul();
        test_undefined();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, registered ALU that replaces the fixed 4-bit combinational ALU with a WIDTH-bit datapath, valid/ready handshakes on input and output, status flags, shift/compare operations and an iterative multi-cycle multiply. It sits between the operand-fetch stage and the result-writeback stage. Results are held in a one-entry output register until consumed.

## Interface
- WIDTH, 8, operand/result width in bits; must be ≥ 2 and a power of two.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  block can accept an operation this cycle.
- op_a  in  WIDTH  operand A.
- op_b  in  WIDTH  operand B.
- alu_op  in  4  operation code.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  downstream consumes the result.
- result  out  WIDTH  operation result.
- flags  out  5  {err, negative, overflow, carry, zero}.

## Operation
- Opcodes:
  - 0 ADD.
  - 1 SUB.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 SHL: a << b[log2(WIDTH)-1:0].
  - 6 SHR: logical, same shift-amount bits.
  - 7 SLT: signed a<b, result 1/0 zero-extended.
  - 8 MUL: low WIDTH bits of unsigned a×b.
  - 9–15: undefined; result 0, err=1, all other flags except zero are 0.
- Transfer occurs on clk edge with in_valid && in_ready; operands and opcode are captured at that edge.
- in_ready = !rst && state==IDLE && (!out_valid || out_ready).
  - Back-to-back single-cycle operations therefore sustain one op per clock.
- Flag rules:
  - zero = (result == 0).
  - negative = result[WIDTH-1].
  - ADD: carry = carry-out; overflow = signed overflow.
  - SUB: carry = borrow (a < b unsigned); overflow = signed overflow.
  - Logic, shift and SLT ops: carry = 0, overflow = 0.
  - MUL: carry = overflow = (upper WIDTH bits of the full product != 0).
- All arithmetic wraps modulo 2^WIDTH.
- Two-state FSM:
  - IDLE: on accepting op 0–7 or 9–15, load the output register and stay in IDLE. On accepting MUL, load the multiplier and go to MULT.
  - MULT: one shift-add step per cycle for WIDTH cycles. After the last step, load the output register and return to IDLE.
- Output register: out_valid is set when loaded. It is cleared on out_valid && out_ready unless a new load happens in the same edge, in which case it stays set with the new data.
- result and flags are stable while out_valid && !out_ready.
- While out_valid && !out_ready, a MULT completion cannot occur: MUL is only accepted when the output is free or being consumed, and MULT holds its final step until the output register is free.

## Timing
- Reset values:
  - out_valid = 0, result = 0, flags = 0, state = IDLE.
  - in_ready = 0 while rst is high; it goes high the first cycle after rst deasserts.
- Single-cycle ops: accepted at edge N → out_valid high from edge N+1.
- MUL: accepted at edge N → out_valid high from edge N+WIDTH+1. in_ready is low throughout MULT.
- Reset asserted mid-MULT aborts the multiply. No result is produced; out_valid = 0 after the reset edge.
- Simultaneous consume and accept: the old result leaves and the new result appears at the next edge with no bubble.
- No combinational path from op_a, op_b or alu_op to any output. in_ready depends combinationally only on out_ready, out_valid, state and rst.

## Structure
- Package alu_pkg:
  - Opcode enum (ALU_ADD … ALU_MUL).
  - Flag bit-index constants: FLG_ZERO=0, FLG_CARRY=1, FLG_OVF=2, FLG_NEG=3, FLG_ERR=4.
  - FSM state typedef.
- Sub-module alu_mul_seq (WIDTH): start/busy/done handshake, shift-add iterative multiplier returning the 2·WIDTH-bit product. The top instantiates one and maps its done signal to the MULT→IDLE transition.
- The single-cycle ops and flag generation are one combinational function inside alu_pipe.

## Test plan
- Reset, then WIDTH=8, ADD 0xFF+0x01 with out_ready=1 → one cycle later result 0x00, zero=1, carry=1, overflow=0.
- SUB 0x80−0x01 → result 0x7F, overflow=1, carry=0. Then SLT 0x80,0x01 → result 0x01.
- MUL 0x10×0x11 → out_valid exactly 9 cycles after accept, result 0x10, carry=overflow=1; in_ready low for those cycles.
- Hold out_ready=0 with a result pending → in_ready=0, result/flags stable for 5 cycles. Raise out_ready together with a new ADD 3+4 → 0x07 the next cycle, with no gap in out_valid.
- Assert rst 3 cycles into a MUL → out_valid stays 0 and in_ready=1 the cycle after rst drops. A subsequent AND 0xF0&0x3C → 0x30.
- Opcode 0xC with any operands → result 0, err=1, zero=1.
